// File: rtl/vga_pkg.sv
// vga_pkg: shared colour/coordinate types for the sprite compositor
package vga_pkg;
  localparam int COORD_BITS = 11;
  typedef logic signed [COORD_BITS-1:0] coord_t;
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;
  localparam rgb_t COLOR_BLACK = 12'h000;
  localparam rgb_t COLOR_WHITE = 12'hFFF;
endpackage

// File: rtl/vga_sprite_hit.sv
// vga_sprite_hit: local coordinates and in-box test for one sprite
// VGA_SPRITE_BBOX_EN adds the outer-ring flag used for outline drawing.
module vga_sprite_hit #(
  parameter int COORD_W  = 11,
  parameter int SPRITE_W = 42,
  parameter int SPRITE_H = 42
) (
  input  logic               en,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [COORD_W-1:0] row,
  input  logic [COORD_W-1:0] col,
  output logic [COORD_W-1:0] lx,
  output logic [COORD_W-1:0] ly,
  output logic               hit,
  output logic               ring
);
  assign lx = col - x;
  assign ly = row - y;
  // a set sign bit means left of / above the box, so the upper bound can compare unsigned
  assign hit = en && !lx[COORD_W-1] && !ly[COORD_W-1] &&
               lx < COORD_W'(SPRITE_W) && ly < COORD_W'(SPRITE_H);
`ifdef VGA_SPRITE_BBOX_EN
  assign ring = lx == '0 || ly == '0 || lx == COORD_W'(SPRITE_W - 1) || ly == COORD_W'(SPRITE_H - 1);
`else
  assign ring = 1'b0;
`endif
endmodule

// File: rtl/vga_sprite_compositor.sv
// vga_sprite_compositor: prioritised, transparency-aware sprite overlay with 2-cycle latency
// Optional VGA_SPRITE_BBOX_EN draws a white 1-px outline on enabled sprite boxes.
module vga_sprite_compositor
  import vga_pkg::*;
#(
  parameter int NUM_SPRITES = 4,
  parameter int SPRITE_W    = 42,
  parameter int SPRITE_H    = 42,
  parameter int COORD_W     = 11
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           pix_valid_i,
  input  logic                           frame_start_i,
  input  logic signed [COORD_W-1:0]      row,
  input  logic signed [COORD_W-1:0]      col,
  input  logic [11:0]                    bg_rgb_i,
  input  logic [NUM_SPRITES*COORD_W-1:0] spr_x_i,
  input  logic [NUM_SPRITES*COORD_W-1:0] spr_y_i,
  input  logic [NUM_SPRITES-1:0]         spr_en_i,
  output logic [NUM_SPRITES*COORD_W-1:0] spr_lx_o,
  output logic [NUM_SPRITES*COORD_W-1:0] spr_ly_o,
  input  logic [NUM_SPRITES*12-1:0]      spr_rgb_i,
  input  logic [NUM_SPRITES-1:0]         spr_opaque_i,
  output logic [3:0]                     red,
  output logic [3:0]                     green,
  output logic [3:0]                     blue,
  output logic                           pix_valid_o,
  output logic [NUM_SPRITES-2:0]         collision_o,
  output logic                           collision_vld_o
);
  localparam int N  = NUM_SPRITES;
  localparam int CW = COORD_W;
  logic [N*CW-1:0] sh_x, sh_y, eff_x, eff_y;
  logic [N-1:0] sh_en, eff_en, hit, ring, ohit, draw;
  logic [N*12-1:0] lay_rgb;
  logic load;
  logic s1_valid, s1_fs;
  logic [N-1:0] s1_ohit, s1_draw;
  logic [N*12-1:0] s1_rgb;
  logic [11:0] s1_bg;
  logic [N-2:0] acc, term;
  rgb_t sel;
  assign load   = pix_valid_i & frame_start_i;
  assign eff_x  = load ? spr_x_i : sh_x;
  assign eff_y  = load ? spr_y_i : sh_y;
  assign eff_en = load ? spr_en_i : sh_en;
  genvar k;
  for (k = 0; k < N; k++) begin : g_spr
    vga_sprite_hit #(.COORD_W(CW), .SPRITE_W(SPRITE_W), .SPRITE_H(SPRITE_H)) u_hit (
      .en(eff_en[k]), .x(eff_x[k*CW+:CW]), .y(eff_y[k*CW+:CW]), .row(row), .col(col),
      .lx(spr_lx_o[k*CW+:CW]), .ly(spr_ly_o[k*CW+:CW]), .hit(hit[k]), .ring(ring[k]));
    assign lay_rgb[k*12+:12] = (hit[k] & ring[k]) ? COLOR_WHITE : spr_rgb_i[k*12+:12];
  end
  assign ohit = hit & spr_opaque_i;
  assign draw = ohit | (hit & ring);
  assign term = {(N-1){s1_ohit[0]}} & s1_ohit[N-1:1];
  always_comb begin
    sel = rgb_t'(s1_bg);
    for (int i = N - 1; i >= 0; i--) sel = s1_draw[i] ? rgb_t'(s1_rgb[i*12+:12]) : sel;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_x <= '0; sh_y <= '0; sh_en <= '0;
      s1_valid <= 1'b0; s1_fs <= 1'b0; s1_ohit <= '0; s1_draw <= '0; s1_rgb <= '0; s1_bg <= '0;
      {red, green, blue} <= COLOR_BLACK;
      pix_valid_o <= 1'b0; collision_o <= '0; collision_vld_o <= 1'b0; acc <= '0;
    end else begin
      if (load) begin
        sh_x <= spr_x_i; sh_y <= spr_y_i; sh_en <= spr_en_i;
      end
      s1_valid <= pix_valid_i;
      s1_fs    <= load;
      s1_ohit  <= pix_valid_i ? ohit : '0;
      s1_draw  <= draw;
      s1_rgb   <= lay_rgb;
      s1_bg    <= bg_rgb_i;
      pix_valid_o <= s1_valid;
      {red, green, blue} <= s1_valid ? sel : COLOR_BLACK;
      collision_vld_o <= s1_valid & s1_fs;
      // the frame_start pixel's own overlap seeds the new frame's accumulator
      if (s1_valid & s1_fs) begin
        collision_o <= acc;
        acc <= term;
      end else if (s1_valid) acc <= acc | term;
    end
  end
endmodule

// File: tb/tb_vga_sprite_compositor.sv
// tb_vga_sprite_compositor: directed scoreboard bench for the sprite compositor
module tb_vga_sprite_compositor;
  localparam int CW = 11;
`ifdef VGA_SPRITE_BBOX_EN
  localparam logic BB = 1'b1;
`else
  localparam logic BB = 1'b0;
`endif
  logic clk = 0, reset = 1, pix_valid_i = 0, frame_start_i = 0;
  logic signed [CW-1:0] row = 0, col = 0;
  logic [11:0] bg_rgb_i = 0;
  logic [4*CW-1:0] spr_x_i = 0, spr_y_i = 0, spr_lx_o, spr_ly_o;
  logic [3:0] spr_en_i = 0, spr_opaque_i = 0;
  logic [47:0] spr_rgb_i = {12'hFF0, 12'h00F, 12'h0F0, 12'hF00};
  logic [3:0] red, green, blue;
  logic pix_valid_o, collision_vld_o;
  logic [2:0] collision_o;
  logic [4*CW-1:0] nx = 0, ny = 0;
  logic [3:0] nen = 0, nopq = 4'hF;
  logic [11:0] exp_q[$];
  logic [2:0] col_q[$];
  int n_cmp = 0, n_err = 0;
  logic done = 0, checked = 0;
  logic [11:0] e;
  logic [2:0] ec;

  vga_sprite_compositor dut (
    .clk(clk), .reset(reset), .pix_valid_i(pix_valid_i), .frame_start_i(frame_start_i),
    .row(row), .col(col), .bg_rgb_i(bg_rgb_i), .spr_x_i(spr_x_i), .spr_y_i(spr_y_i),
    .spr_en_i(spr_en_i), .spr_lx_o(spr_lx_o), .spr_ly_o(spr_ly_o), .spr_rgb_i(spr_rgb_i),
    .spr_opaque_i(spr_opaque_i), .red(red), .green(green), .blue(blue),
    .pix_valid_o(pix_valid_o), .collision_o(collision_o), .collision_vld_o(collision_vld_o));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset && $time > 10) begin
      n_cmp++;
      if ({red, green, blue, pix_valid_o, collision_o, collision_vld_o} !== '0) begin
        n_err++;
        $display("FAIL reset: rgb=%h pv=%b col=%b cv=%b, required all zero", {red, green, blue}, pix_valid_o, collision_o, collision_vld_o);
      end
    end
    if (pix_valid_o) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL pix: unexpected output rgb=%h, none required", {red, green, blue});
      end else begin
        e = exp_q.pop_front();
        if ({red, green, blue} !== e) begin
          n_err++;
          $display("FAIL pix: got %h required %h", {red, green, blue}, e);
        end
      end
    end
    if (collision_vld_o) begin
      n_cmp++;
      if (col_q.size() == 0) begin
        n_err++;
        $display("FAIL coll: unexpected pulse collision_o=%b", collision_o);
      end else begin
        ec = col_q.pop_front();
        if (collision_o !== ec) begin
          n_err++;
          $display("FAIL coll: got %b required %b", collision_o, ec);
        end
      end
    end
    if (done && !checked) begin
      n_cmp++;
      if (exp_q.size() != 0 || col_q.size() != 0) begin
        n_err++;
        $display("FAIL drain: %0d pixels and %0d collisions outstanding, required 0", exp_q.size(), col_q.size());
      end
      checked <= 1;
    end
  end

  task automatic px(input int r, input int c, input logic fs, input logic [11:0] bg, input logic [11:0] ex);
    @(posedge clk); #1;
    row = CW'(r); col = CW'(c); frame_start_i = fs; bg_rgb_i = bg; pix_valid_i = 1;
    spr_x_i = nx; spr_y_i = ny; spr_en_i = nen; spr_opaque_i = nopq;
    exp_q.push_back(ex);
  endtask

  task automatic place(input int k, input int x, input int y);
    nx[k*CW+:CW] = CW'(x); ny[k*CW+:CW] = CW'(y);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 0;
    // sprites requested but never latched: background only
    nen = 4'hF;
    px(0, 0, 0, 12'h111, 12'h111);
    px(0, 1, 0, 12'h222, 12'h222);
    px(0, 2, 0, 12'h333, 12'h333);
    // sprite 1 at (100,50)
    nen = 4'b0010; place(1, 100, 50);
    px(0, 0, 1, 12'h123, 12'h123); col_q.push_back(3'b000);
    px(50, 99, 0, 12'h456, 12'h456);
    px(50, 100, 0, 12'h456, BB ? 12'hFFF : 12'h0F0);
    px(50, 141, 0, 12'h456, BB ? 12'hFFF : 12'h0F0);
    px(50, 142, 0, 12'h456, 12'h456);
    // sprites 0 and 2 stacked at (200,200)
    nen = 4'b0101; place(0, 200, 200); place(2, 200, 200);
    px(0, 0, 1, 12'h050, 12'h050); col_q.push_back(3'b000);
    px(210, 210, 0, 12'h050, 12'hF00);
    nopq = 4'b1110;
    px(210, 215, 0, 12'h050, 12'h00F);
    nopq = 4'hF;
    // mid-frame move of sprite 1 is deferred to the next frame
    nen = 4'b0010; place(1, 10, 10);
    px(0, 0, 1, 12'h007, 12'h007); col_q.push_back(3'b010);
    px(20, 20, 0, 12'h007, 12'h0F0);
    place(1, 300, 10);
    px(20, 20, 0, 12'h007, 12'h0F0);
    px(20, 310, 0, 12'h007, 12'h007);
    px(0, 0, 1, 12'h008, 12'h008); col_q.push_back(3'b000);
    px(20, 310, 0, 12'h008, 12'h0F0);
    px(20, 20, 0, 12'h008, 12'h008);
    // sprites 0 and 3 overlap at (400,300)
    nen = 4'b1001; place(0, 400, 300); place(3, 400, 300);
    px(0, 0, 1, 12'h00A, 12'h00A); col_q.push_back(3'b000);
    px(310, 410, 0, 12'h00A, 12'hF00);
    px(310, 460, 0, 12'h00A, 12'h00A);
    px(0, 0, 1, 12'h00B, 12'h00B); col_q.push_back(3'b100);
    // sprite 2 clipped at x=-20
    nen = 4'b0100; place(2, -20, 0);
    px(100, 0, 1, 12'h0C0, 12'h0C0); col_q.push_back(3'b000);
    px(5, 0, 0, 12'h0C0, 12'h00F);
    #1;
    n_cmp++;
    if (spr_lx_o[2*CW+:CW] !== 11'd20) begin
      n_err++;
      $display("FAIL lx_clip: got %0d required 20", spr_lx_o[2*CW+:CW]);
    end
    px(5, 21, 0, 12'h0C0, BB ? 12'hFFF : 12'h00F);
    px(5, 22, 0, 12'h0C0, 12'h0C0);
    @(posedge clk); #1 pix_valid_i = 0; frame_start_i = 0;
    repeat (5) @(posedge clk);
    done = 1;
    wait (checked);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
